graphics_cmd_master: RTL



---
 rtl/graphics_cmd_master.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/graphics_cmd_master.sv
// Bus master that replays a queued draw request as 68000-style word writes
// to the graphics controller, then polls its status word until idle.
module graphics_cmd_master #(
    parameter int unsigned STROBE_CYCLES = 2,
    parameter int unsigned MAX_POLLS     = 255,
    parameter logic [15:0] X1_ADDR       = 16'h0002,
    parameter logic [15:0] Y1_ADDR       = 16'h0004,
    parameter logic [15:0] X2_ADDR       = 16'h0006,
    parameter logic [15:0] Y2_ADDR       = 16'h0008,
    parameter logic [15:0] COLOUR_ADDR   = 16'h000E,
    parameter logic [15:0] CMD_ADDR      = 16'h0000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req_Valid,
    output logic        Req_Ready,
    input  logic [15:0] Req_Cmd,
    input  logic [15:0] Req_X1,
    input  logic [15:0] Req_Y1,
    input  logic [15:0] Req_X2,
    input  logic [15:0] Req_Y2,
    input  logic [15:0] Req_Colour,
    output logic        Busy,
    output logic        Done,
    output logic        Timeout,
    output logic [15:0] AddressOut,
    output logic [15:0] DataOut,
    input  logic [15:0] DataIn,
    output logic        AS_L,
    output logic        UDS_L,
    output logic        LDS_L,
    output logic        GraphicsCS_L,
    output logic        RW
);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_RELEASE} phase_t;

    // step 0..5 are the register writes in bus order, step 6 is a status poll
    localparam logic [2:0] STEP_CMD    = 3'd5;
    localparam logic [2:0] STEP_POLL   = 3'd6;
    localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYCLES - 1);
    localparam logic [7:0] POLL_LIMIT  = 8'(MAX_POLLS);

    phase_t      state, state_next;
    logic        done_next, timeout_next;
    logic [2:0]  step;
    logic [3:0]  strobe_cnt;
    logic [7:0]  poll_cnt;
    logic        idle_seen;
    logic [15:0] x1_q, y1_q, x2_q, y2_q, colour_q, cmd_q;
    logic        accept, poll_sample;
    logic        unused_data_bits;

    assign accept           = Req_Valid && Req_Ready;
    assign poll_sample      = (state == S_STROBE) && (strobe_cnt == STROBE_LAST) && (step == STEP_POLL);
    // only the idle flag of the status word matters
    assign unused_data_bits = ^DataIn[15:1];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= S_IDLE;
            Done    <= 1'b0;
            Timeout <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values
            state   <= state_next;
            Done    <= done_next;
            Timeout <= timeout_next;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned and infers a latch
        state_next   = state;
        done_next    = 1'b0;
        timeout_next = 1'b0;
        unique case (state)
            S_IDLE:   if (accept) state_next = S_SETUP;
            S_SETUP:  state_next = S_STROBE;
            S_STROBE: if (strobe_cnt == STROBE_LAST) state_next = S_RELEASE;
            S_RELEASE: begin
                if (step < STEP_CMD) begin
                    state_next = S_SETUP;
                end else if (step == STEP_CMD) begin
                    if (MAX_POLLS == 0) begin
                        state_next = S_IDLE;
                        done_next  = 1'b1;
                    end else begin
                        state_next = S_SETUP;
                    end
                end else if (idle_seen) begin
                    state_next = S_IDLE;
                    done_next  = 1'b1;
                end else if (poll_cnt == POLL_LIMIT) begin
                    state_next   = S_IDLE;
                    timeout_next = 1'b1;
                end else begin
                    state_next = S_SETUP;
                end
            end
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            step       <= '0;
            strobe_cnt <= '0;
            poll_cnt   <= '0;
            idle_seen  <= 1'b0;
        end else begin
            strobe_cnt <= (state == S_STROBE) ? strobe_cnt + 4'd1 : 4'd0;
            if (accept) begin
                step      <= '0;
                poll_cnt  <= '0;
                idle_seen <= 1'b0;
            end else begin
                if (state == S_RELEASE && state_next == S_SETUP && step != STEP_POLL)
                    step <= step + 3'd1;
                if (poll_sample) begin
                    idle_seen <= DataIn[0];
                    if (!DataIn[0]) poll_cnt <= poll_cnt + 8'd1;
                end
            end
        end
    end

    // NOTE: request holding registers carry no reset; they are only read after an accept loads them
    always_ff @(posedge Clk) begin
        if (accept) begin
            x1_q     <= Req_X1;
            y1_q     <= Req_Y1;
            x2_q     <= Req_X2;
            y2_q     <= Req_Y2;
            colour_q <= Req_Colour;
            cmd_q    <= Req_Cmd;
        end
    end

    always_comb begin
        Req_Ready    = (state == S_IDLE) && !Reset;
        Busy         = (state != S_IDLE);
        AS_L         = (state != S_STROBE);
        UDS_L        = (state != S_STROBE);
        LDS_L        = (state != S_STROBE);
        GraphicsCS_L = (state != S_STROBE);
        AddressOut   = '0;
        DataOut      = '0;
        RW           = 1'b1;
        if (state != S_IDLE) begin
            RW = 1'b0;
            unique case (step)
                3'd0: begin AddressOut = X1_ADDR;     DataOut = x1_q;     end
                3'd1: begin AddressOut = Y1_ADDR;     DataOut = y1_q;     end
                3'd2: begin AddressOut = X2_ADDR;     DataOut = x2_q;     end
                3'd3: begin AddressOut = Y2_ADDR;     DataOut = y2_q;     end
                3'd4: begin AddressOut = COLOUR_ADDR; DataOut = colour_q; end
                3'd5: begin AddressOut = CMD_ADDR;    DataOut = cmd_q;    end
                default: begin
                    AddressOut = CMD_ADDR;
                    RW         = 1'b1;
                end
            endcase
        end
    end

endmodule
